// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external bus master: FSM states, default sizes
// and a saturating counter helper.
package ext_bus_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RSP
  } bus_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ext_bus_master_if.sv
// Command/response and external request/ack signals of the bus master.
// The master modport is the ext_bus_master view; slave is the surrounding logic.
interface ext_bus_master_if
  import ext_bus_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_is_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [WIDTH-1:0]      cmd_wr_data;
  logic [WIDTH-1:0]      cmd_wr_biten;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_is_wr;
  logic [WIDTH-1:0]      rsp_rd_data;
  logic                  rsp_err;

  logic                  req;
  logic                  req_is_wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wr_data;
  logic [WIDTH-1:0]      wr_biten;
  logic                  rd_ack;
  logic [WIDTH-1:0]      rd_data;
  logic                  wr_ack;

  modport master (
    input  cmd_valid, cmd_is_wr, cmd_addr, cmd_wr_data, cmd_wr_biten,
    input  rsp_ready, rd_ack, rd_data, wr_ack,
    output cmd_ready, rsp_valid, rsp_is_wr, rsp_rd_data, rsp_err,
    output req, req_is_wr, addr, wr_data, wr_biten
  );

  modport slave (
    output cmd_valid, cmd_is_wr, cmd_addr, cmd_wr_data, cmd_wr_biten,
    output rsp_ready, rd_ack, rd_data, wr_ack,
    input  cmd_ready, rsp_valid, rsp_is_wr, rsp_rd_data, rsp_err,
    input  req, req_is_wr, addr, wr_data, wr_biten
  );

endinterface

// File: rtl/ext_bus_timer.sv
// Ack wait counter: cleared before each wait phase, counts unacknowledged
// wait cycles and flags the cycle in which the count reaches TIMEOUT.
module ext_bus_timer
  import ext_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 8'd1;
    end
  end

  // enable already excludes a matching ack, so an ack in the final cycle wins
  assign expired = enable && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/ext_bus_master.sv
// Single-outstanding external bus master: accepts one command, issues a
// one-cycle request, waits for the matching ack or a timeout, returns a response.
module ext_bus_master
  import ext_bus_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  ext_bus_master_if.master     bus,
  output logic [7:0]           timeout_cnt
);

  bus_state_e state;
  logic       match_ack;
  logic       timer_clear;
  logic       timer_enable;
  logic       expired;

  // req_is_wr doubles as the registered command direction
  assign match_ack    = bus.req_is_wr ? bus.wr_ack : bus.rd_ack;
  assign timer_clear  = (state == REQ);
  assign timer_enable = (state == WAIT) && !match_ack;

  ext_bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      bus.cmd_ready   <= 1'b1;
      bus.req         <= 1'b0;
      bus.req_is_wr   <= 1'b0;
      bus.addr        <= '0;
      bus.wr_data     <= '0;
      bus.wr_biten    <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_is_wr   <= 1'b0;
      bus.rsp_rd_data <= '0;
      bus.rsp_err     <= 1'b0;
      timeout_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            bus.req       <= 1'b1;
            bus.req_is_wr <= bus.cmd_is_wr;
            bus.addr      <= bus.cmd_addr;
            bus.wr_data   <= bus.cmd_is_wr ? bus.cmd_wr_data  : '0;
            bus.wr_biten  <= bus.cmd_is_wr ? bus.cmd_wr_biten : '0;
            state         <= REQ;
          end
        end
        REQ: begin
          bus.req <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (match_ack) begin
            bus.rsp_valid   <= 1'b1;
            bus.rsp_is_wr   <= bus.req_is_wr;
            bus.rsp_rd_data <= bus.req_is_wr ? '0 : bus.rd_data;
            bus.rsp_err     <= 1'b0;
            state           <= RSP;
          end else if (expired) begin
            bus.rsp_valid   <= 1'b1;
            bus.rsp_is_wr   <= bus.req_is_wr;
            bus.rsp_rd_data <= '0;
            bus.rsp_err     <= 1'b1;
            timeout_cnt     <= sat_inc8(timeout_cnt);
            state           <= RSP;
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_master.sv
// Directed plus randomized bench for ext_bus_master; expected responses come
// from a memory-backed transaction model and the ack/timeout timing rules.
module tb_ext_bus_master;

  localparam int W  = 32;
  localparam int AW = 8;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] timeout_cnt;

  ext_bus_master_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  ext_bus_master #(
    .WIDTH      (W),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_to = 0;
  logic [W-1:0] mem [logic [AW-1:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // dly: cycles after req until the responder acks (<1 = never);
  // wrong: responder uses the other ack; stray: acks in RSP and IDLE.
  task automatic do_txn(input bit is_wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic [W-1:0] b, input int dly, input bit wrong,
                        input int hold, input bit stray);
    bit           exp_err, ok, ok2;
    int           k_exp, j;
    logic [W-1:0] exp_data, exp_wd, exp_be;
    exp_err  = (dly < 1) || (dly > TO) || wrong;
    k_exp    = exp_err ? TO : dly;
    exp_wd   = is_wr ? d : '0;
    exp_be   = is_wr ? b : '0;
    exp_data = (exp_err || is_wr) ? '0 : mem_rd(a);
    if (exp_err) exp_to = (exp_to < 255) ? exp_to + 1 : 255;

    chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid    = 1'b1;
    bus.cmd_is_wr    = is_wr;
    bus.cmd_addr     = a;
    bus.cmd_wr_data  = d;
    bus.cmd_wr_biten = b;
    @(negedge clk);
    bus.cmd_valid    = 1'b0;
    bus.cmd_wr_data  = $urandom;
    bus.cmd_wr_biten = $urandom;
    bus.cmd_addr     = 8'($urandom);
    chk("req_pulse", {61'd0, bus.req, bus.req_is_wr, bus.cmd_ready}, {61'd0, 1'b1, is_wr, 1'b0});
    chk("req_addr", 64'(bus.addr), 64'(a));
    chk("req_wdata", 64'(bus.wr_data), 64'(exp_wd));
    chk("req_biten", 64'(bus.wr_biten), 64'(exp_be));

    ok = 1'b1;
    j  = 0;
    while (bus.rsp_valid !== 1'b1 && j < TO + 4) begin
      @(negedge clk);
      j++;
      if (bus.rsp_valid !== 1'b1) begin
        if (bus.req !== 1'b0 || bus.addr !== a || bus.wr_data !== exp_wd ||
            bus.wr_biten !== exp_be || bus.req_is_wr !== is_wr || bus.cmd_ready !== 1'b0)
          ok = 1'b0;
        // ack driven here is sampled at the end of wait cycle j
        bus.wr_ack  = (j == dly) && (is_wr ^ wrong);
        bus.rd_ack  = (j == dly) && !(is_wr ^ wrong);
        bus.rd_data = (j == dly) ? mem_rd(a) : W'($urandom);
      end
    end
    bus.wr_ack = 1'b0;
    bus.rd_ack = 1'b0;
    chk("wait_hold", 64'(ok), 64'd1);
    // latency counted inclusively: command cycle through first response cycle
    chk("latency", 64'(j + 2), 64'(3 + k_exp));
    chk("rsp_is_wr", 64'(bus.rsp_is_wr), 64'(is_wr));
    chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    chk("rsp_rd_data", 64'(bus.rsp_rd_data), 64'(exp_data));
    chk("timeout_cnt", 64'(timeout_cnt), 64'(exp_to));

    ok2 = 1'b1;
    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = 1'b0;
      bus.rd_ack    = stray;
      bus.wr_ack    = stray;
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_is_wr !== is_wr || bus.rsp_err !== exp_err ||
          bus.rsp_rd_data !== exp_data || bus.cmd_ready !== 1'b0 || bus.req !== 1'b0)
        ok2 = 1'b0;
    end
    if (hold > 0) chk("rsp_stall", 64'(ok2), 64'd1);
    bus.rd_ack    = 1'b0;
    bus.wr_ack    = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_done", {61'd0, bus.rsp_valid, bus.cmd_ready, bus.req}, 64'b010);
    if (stray) begin
      bus.rd_ack = 1'b1;
      bus.wr_ack = 1'b1;
      @(negedge clk);
      bus.rd_ack = 1'b0;
      bus.wr_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_ignored", {61'd0, bus.rsp_valid, bus.cmd_ready, bus.req}, 64'b010);
    end
    if (is_wr && !exp_err) mem[a] = (mem_rd(a) & ~b) | (d & b);
  endtask

  initial begin
    bit ok;
    bus.cmd_valid    = 1'b0;
    bus.cmd_is_wr    = 1'b0;
    bus.cmd_addr     = '0;
    bus.cmd_wr_data  = '0;
    bus.cmd_wr_biten = '0;
    bus.rsp_ready    = 1'b0;
    bus.rd_ack       = 1'b0;
    bus.wr_ack       = 1'b0;
    bus.rd_data      = '0;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {59'd0, bus.cmd_ready, bus.req, bus.rsp_valid, bus.rsp_err, bus.rsp_is_wr},
        64'b10000);
    chk("rst_data", {bus.rsp_rd_data, bus.wr_data}, 64'd0);
    chk("rst_addr", {48'd0, bus.addr, timeout_cnt}, 64'd0);
    chk("rst_biten", 64'(bus.wr_biten), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // basic write then readback, 1- and 3-cycle ack delays
    do_txn(1'b1, 8'h10, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 1, 1'b0, 0, 1'b0);
    do_txn(1'b0, 8'h10, '0, '0, 3, 1'b0, 0, 1'b0);
    // silent responder with late acks, then a normal read
    do_txn(1'b0, 8'h44, '0, '0, -1, 1'b0, 2, 1'b1);
    do_txn(1'b0, 8'h10, '0, '0, 2, 1'b0, 0, 1'b0);
    // ack in the expiring cycle wins; wrong-type ack is ignored
    do_txn(1'b1, 8'h30, 32'h1234_5678, 32'h0F0F_F0F0, TO, 1'b0, 0, 1'b0);
    do_txn(1'b1, 8'h31, 32'hDEAD_BEEF, 32'hFFFF_0000, 2, 1'b1, 0, 1'b0);
    do_txn(1'b0, 8'h30, '0, '0, TO, 1'b0, 0, 1'b0);
    // response backpressure
    do_txn(1'b1, 8'h10, 32'h0BAD_F00D, 32'h00FF_FF00, 1, 1'b0, 5, 1'b0);

    // reset while waiting for an ack
    bus.cmd_valid = 1'b1;
    bus.cmd_is_wr = 1'b0;
    bus.cmd_addr  = 8'h20;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_to = 0;
    chk("rst_wait_ctrl", {59'd0, bus.cmd_ready, bus.req, bus.rsp_valid, bus.rsp_err, bus.rsp_is_wr},
        64'b10000);
    chk("rst_wait_cnt", {48'd0, bus.addr, timeout_cnt}, 64'd0);
    bus.rd_ack = 1'b1;
    bus.wr_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
    bus.wr_ack = 1'b0;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.req !== 1'b0) ok = 1'b0;
    end
    chk("rst_no_rsp", 64'(ok), 64'd1);

    // randomized traffic over a small address window
    for (int n = 0; n < 40; n++) begin
      int dly;
      dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, TO));
      do_txn(1'($urandom_range(0, 1)), 8'(8'h10 + $urandom_range(0, 3)), W'($urandom),
             W'($urandom), dly, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
    end

    // timeout counter saturation
    for (int n = 0; n < 300; n++) begin
      do_txn(1'($urandom_range(0, 1)), 8'($urandom), W'($urandom), W'($urandom), -1, 1'b0, 0,
             1'b0);
    end
    chk("timeout_sat", 64'(timeout_cnt), 64'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
